// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared types and constants for the AXI-lite interconnect sequencers
//   SEL_W       width of the slave-select field
//   RESP_*      B response encodings
//   state_t     write/read sequencer states
package axi_ic_pkg;
  localparam int SEL_W = 3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DERR_AW, DERR_DATA, DERR_RESP} state_t;
endpackage

// File: rtl/aw_wr_sequencer_if.sv
// aw_wr_sequencer_if: master-side AW/W/B and per-slave AW/W handshake bundle
//   slave  modport: seen by the sequencer (consumes master/slave inputs, drives readies/valids/status)
//   master modport: seen by the environment driving the sequencer
interface aw_wr_sequencer_if #(parameter int num_slaves = 5, parameter int ADDR_W = 32, parameter int CNT_W = 8);
  logic [ADDR_W-1:0] m_awaddr;
  logic m_awvalid;
  logic m_awready;
  logic [num_slaves-1:0] s_awvalid;
  logic [num_slaves-1:0] s_awready;
  logic m_wvalid;
  logic m_wlast;
  logic m_wready;
  logic [num_slaves-1:0] s_wvalid;
  logic [num_slaves-1:0] s_wready;
  logic m_bvalid;
  logic m_bready;
  logic [2:0] aw_sel_q;
  logic err_bvalid;
  logic [1:0] err_bresp;
  logic busy;
  logic [CNT_W-1:0] decerr_cnt;
  modport slave (
    input m_awaddr, m_awvalid, s_awready, m_wvalid, m_wlast, s_wready, m_bvalid, m_bready,
    output m_awready, s_awvalid, m_wready, s_wvalid, aw_sel_q, err_bvalid, err_bresp, busy, decerr_cnt
  );
  modport master (
    output m_awaddr, m_awvalid, s_awready, m_wvalid, m_wlast, s_wready, m_bvalid, m_bready,
    input m_awready, s_awvalid, m_wready, s_wvalid, aw_sel_q, err_bvalid, err_bresp, busy, decerr_cnt
  );
endinterface

// File: rtl/aw_addr_decoder.sv
// aw_addr_decoder: combinational address -> {slave index, hit} decode
//   i_addr  address to decode
//   o_sel   3-bit select field addr[SEL_LSB+2:SEL_LSB]
//   o_hit   select names an existing slave
module aw_addr_decoder
  import axi_ic_pkg::*;
#(
  parameter int num_slaves = 5,
  parameter int ADDR_W = 32,
  parameter int SEL_LSB = 28
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_hit
);
  logic w_unused;
  assign o_sel = i_addr[SEL_LSB+:SEL_W];
  assign o_hit = int'(o_sel) < num_slaves;
  // only the select field matters; the rest of the address is routed elsewhere
  assign w_unused = ^i_addr;
endmodule

// File: rtl/aw_wr_sequencer.sv
// aw_wr_sequencer: one-at-a-time AW -> W -> B write sequencer with local DECERR
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         aw_wr_sequencer_if.slave: master AW/W/B, per-slave AW/W, aw_sel_q,
//               err_bvalid/err_bresp, busy, decerr_cnt
module aw_wr_sequencer
  import axi_ic_pkg::*;
#(
  parameter int num_slaves = 5,
  parameter int ADDR_W = 32,
  parameter int SEL_LSB = 28,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  aw_wr_sequencer_if.slave bus
);
  state_t r_state, w_next;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic [CNT_W-1:0] r_cnt;
  logic w_hit;
  logic [num_slaves-1:0] w_oh;
  logic w_awrdy, w_wrdy;

  aw_addr_decoder #(.num_slaves(num_slaves), .ADDR_W(ADDR_W), .SEL_LSB(SEL_LSB)) u_dec (
    .i_addr(bus.m_awaddr),
    .o_sel (w_sel),
    .o_hit (w_hit)
  );

  // one-hot of the latched select; out-of-range selects give all zeros
  for (genvar i = 0; i < num_slaves; i++) begin : g_oh
    assign w_oh[i] = r_sel == SEL_W'(i);
  end

  assign w_awrdy = |(bus.s_awready & w_oh);
  assign w_wrdy = |(bus.s_wready & w_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.m_awvalid) r_sel <= w_sel;
      if (r_state == DERR_RESP && bus.m_bready && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    bus.m_awready = 1'b0;
    bus.s_awvalid = '0;
    bus.m_wready = 1'b0;
    bus.s_wvalid = '0;
    bus.err_bvalid = 1'b0;
    bus.err_bresp = RESP_OKAY;
    case (r_state)
      IDLE: if (bus.m_awvalid) w_next = w_hit ? ADDR : DERR_AW;
      ADDR: begin
        bus.s_awvalid = w_oh & {num_slaves{bus.m_awvalid}};
        bus.m_awready = w_awrdy;
        if (bus.m_awvalid && w_awrdy) w_next = DATA;
      end
      DATA: begin
        bus.s_wvalid = w_oh & {num_slaves{bus.m_wvalid}};
        bus.m_wready = w_wrdy;
        if (bus.m_wvalid && w_wrdy && bus.m_wlast) w_next = RESP;
      end
      RESP: if (bus.m_bvalid && bus.m_bready) w_next = IDLE;
      DERR_AW: begin
        bus.m_awready = 1'b1;
        w_next = DERR_DATA;
      end
      DERR_DATA: begin
        bus.m_wready = 1'b1;
        if (bus.m_wvalid && bus.m_wlast) w_next = DERR_RESP;
      end
      DERR_RESP: begin
        bus.err_bvalid = 1'b1;
        bus.err_bresp = RESP_DECERR;
        if (bus.m_bready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.busy = r_state != IDLE;
  assign bus.aw_sel_q = r_sel;
  assign bus.decerr_cnt = r_cnt;
endmodule

// File: doc/aw_wr_sequencer.md
Name: aw_wr_sequencer

Overview:
Write-path controller for the single-master, N-slave AXI-lite interconnect.
- Decodes each AW address into a slave index and registers it as aw_sel_q, which steers the B-response router.
- Sequences exactly one write transaction at a time through three phases: AW, then W, then B.
- Generates a local DECERR response for unmapped addresses.

Parameters:
num_slaves, 5, number of slave ports (1..8)
ADDR_W, 32, AW address width
SEL_LSB, 28, low bit of the 3-bit slave-select field in awaddr (select = awaddr[SEL_LSB+2:SEL_LSB])
CNT_W, 8, width of the saturating DECERR event counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
m_awaddr  in  ADDR_W  master write address
m_awvalid  in  1  master AW valid
m_awready  out  1  master AW ready
s_awvalid  out  num_slaves  per-slave AW valid
s_awready  in  num_slaves  per-slave AW ready
m_wvalid  in  1  master W valid
m_wlast  in  1  master W last beat
m_wready  out  1  master W ready
s_wvalid  out  num_slaves  per-slave W valid
s_wready  in  num_slaves  per-slave W ready
m_bvalid  in  1  B valid seen at the B-router master side
m_bready  in  1  master B ready
aw_sel_q  out  3  registered slave index; drives the B router select
err_bvalid  out  1  local DECERR B valid; top level muxes it over the router output
err_bresp  out  2  local B response, constant 2'b11 while err_bvalid is high
busy  out  1  high in any state other than IDLE
decerr_cnt  out  CNT_W  saturating count of DECERR transactions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, aw_sel_q=0, decerr_cnt=0.
- All outputs are combinational from state and aw_sel_q. In IDLE they are all 0; err_bresp is 2'b00 whenever err_bvalid is 0.
- FSM states: IDLE, ADDR, DATA, RESP, DERR_AW, DERR_DATA, DERR_RESP.
- IDLE:
  - m_awready=0.
  - When m_awvalid=1, decode sel = awaddr field.
  - If sel < num_slaves: aw_sel_q<=sel, next state ADDR.
  - Otherwise: aw_sel_q<=sel, next state DERR_AW.
  - One cycle of decode latency always applies; there is no AW bypass.
- ADDR:
  - s_awvalid[aw_sel_q]=m_awvalid; m_awready=s_awready[aw_sel_q]; all other s_awvalid bits are 0.
  - On the m_awvalid & m_awready handshake, go to DATA.
- DATA:
  - s_wvalid[aw_sel_q]=m_wvalid; m_wready=s_wready[aw_sel_q].
  - On a W handshake with m_wlast=1, go to RESP.
  - W beats presented before DATA see m_wready=0, so early W is held off.
- RESP:
  - All ready/valid outputs are 0; the B router carries the response using aw_sel_q.
  - On m_bvalid & m_bready, go to IDLE.
- DERR_AW: m_awready=1 for exactly one cycle (m_awvalid is guaranteed high), then go to DERR_DATA.
- DERR_DATA: m_wready=1; all beats are sunk and no s_wvalid bit is asserted. On a handshake with m_wlast=1, go to DERR_RESP.
- DERR_RESP:
  - err_bvalid=1, err_bresp=2'b11.
  - On m_bready, go to IDLE and increment decerr_cnt, saturating at all-ones.
- Invariants:
  - aw_sel_q changes only on the IDLE exit and is stable from ADDR through RESP and through the DERR states.
  - At most one s_awvalid bit and at most one s_wvalid bit are high in any cycle.
  - A new AW is never accepted before the previous B handshake.
  - m_bvalid arriving outside RESP is ignored.
- The back-to-back minimum is one idle cycle between B completion and the next AW decode.
- Reset mid-transaction returns to IDLE immediately. Partial slave transfers are abandoned; slaves are reset by the same rst_n.

Decomposition:
Shared package axi_ic_pkg holds:
- The state enum.
- RESP_OKAY=2'b00 and RESP_DECERR=2'b11.
- SEL_W=3.

One sub-module, aw_addr_decoder, is natural: combinational address to {sel, hit} decode, reused later by the read-path sequencer.

Test Plan:
- Mapped write: awaddr=0x2000_0010, 1 W beat with wlast, slave 2 returns B OKAY -> aw_sel_q=2, s_awvalid=5'b00100, s_wvalid=5'b00100, busy falls the cycle after the B handshake, decerr_cnt=0.
- Unmapped write: awaddr=0x6000_0000 (sel 6), 3 W beats -> m_awready pulses once, 3 beats sunk with s_wvalid=0, err_bvalid=1 with err_bresp=2'b11 until m_bready, decerr_cnt=1.
- Early W and stalled slave: W valid before AW, s_awready[1] held low 4 cycles -> m_wready=0 until DATA, AW handshake on the 5th cycle, aw_sel_q=1 throughout.
- Back-to-back: writes to slave 0 then slave 4 with m_awvalid held high -> second AW not accepted until after the first B handshake, aw_sel_q goes 0 then 4, never two s_awvalid bits high.
- Reset mid-DATA: rst_n low during the 2nd of 4 beats -> outputs all 0 and aw_sel_q=0 without a clock edge, after release state is IDLE and busy=0.
- Counter saturation (CNT_W=2): 5 unmapped writes -> decerr_cnt reads 1,2,3,3,3.
